// File: rtl/hash_pkg.sv
// ---------------------------------------------------------------------------
// hash_pkg
// Shared definitions for the hash-table request path.
//   op_t      : 2-bit request opcode carried in the top bits of every word
//   OP_WIDTH  : width of the opcode field
// ---------------------------------------------------------------------------
package hash_pkg;

    localparam int OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP    = 2'b00,
        OP_READ   = 2'b01,
        OP_WRITE  = 2'b10,
        OP_DELETE = 2'b11
    } op_t;

endpackage

// File: rtl/hash_req_fifo.sv
// ---------------------------------------------------------------------------
// hash_req_fifo
// Single-clock FIFO buffering one requester channel. The head word is
// presented combinationally so the arbiter can pop it in the same cycle
// it is granted.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   i_push     : enqueue i_data (ignored while full)
//   i_pop      : dequeue head   (ignored while empty)
//   o_data     : current head word
//   o_full     : no free entry
//   o_empty    : no stored entry
// ---------------------------------------------------------------------------
module hash_req_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // address bits are equal.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately not reset; resetting the pointers makes
    // every stale entry unreachable, and leaving the array reset-free keeps
    // it mappable to plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // Independent pointer updates give a net-zero occupancy change
            // on a simultaneous push and pop.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/hash_req_arbiter.sv
// ---------------------------------------------------------------------------
// hash_req_arbiter
// Merges NUM_CHANNELS request streams toward a hash table. Each channel is
// buffered in its own FIFO; a round-robin arbiter pops one head per cycle
// into a single output register. Opcode statistics are kept in saturating
// counters.
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   data_i, valid_i : per-channel {op, key, data} request and valid
//   ready_o         : per-channel accept (FIFO not full, low in reset)
//   data_o, chan_o  : granted request and its source channel
//   valid_o,ready_i : output stream handshake
//   read_cnt, write_cnt, delete_cnt : output handshakes per opcode
//   drop_cnt        : accepted nop requests (discarded)
// ---------------------------------------------------------------------------
module hash_req_arbiter
    import hash_pkg::*;
#(
    parameter int KEY_WIDTH    = 32,
    parameter int DATA_WIDTH   = 30,
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [NUM_CHANNELS*(2+KEY_WIDTH+DATA_WIDTH)-1:0]     data_i,
    input  logic [NUM_CHANNELS-1:0]                              valid_i,
    output logic [NUM_CHANNELS-1:0]                              ready_o,
    output logic [(2+KEY_WIDTH+DATA_WIDTH)-1:0]                  data_o,
    output logic [$clog2(NUM_CHANNELS)-1:0]                      chan_o,
    output logic                                                 valid_o,
    input  logic                                                 ready_i,
    output logic [CNT_WIDTH-1:0]                                 read_cnt,
    output logic [CNT_WIDTH-1:0]                                 write_cnt,
    output logic [CNT_WIDTH-1:0]                                 delete_cnt,
    output logic [CNT_WIDTH-1:0]                                 drop_cnt
);

    localparam int W  = OP_WIDTH + KEY_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(NUM_CHANNELS);
    // Headroom so up to 16 simultaneous drops can be added before clamping.
    localparam int SW = CNT_WIDTH + 5;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

    logic [W-1:0]            w_req   [NUM_CHANNELS];
    logic [W-1:0]            w_head  [NUM_CHANNELS];
    logic [CW-1:0]           w_cand  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_full;
    logic [NUM_CHANNELS-1:0] w_empty;
    logic [NUM_CHANNELS-1:0] w_accept;
    logic [NUM_CHANNELS-1:0] w_nop;
    logic [NUM_CHANNELS-1:0] w_push;
    logic [NUM_CHANNELS-1:0] w_pop;
    logic [4:0]              w_nop_count;
    logic [SW-1:0]           w_drop_sum;
    logic                    w_load;
    logic                    w_any;
    logic [CW-1:0]           w_grant;
    logic                    w_out_fire;
    op_t                     w_out_op;

    logic [W-1:0]            r_data;
    logic [CW-1:0]           r_chan;
    logic                    r_valid;
    logic [CW-1:0]           r_last_grant;
    logic [CNT_WIDTH-1:0]    r_read_cnt;
    logic [CNT_WIDTH-1:0]    r_write_cnt;
    logic [CNT_WIDTH-1:0]    r_delete_cnt;
    logic [CNT_WIDTH-1:0]    r_drop_cnt;

    // The output register can take a new word when empty or being drained.
    assign w_load = ~r_valid | ready_i;

    // ------------------------------------------------------------------
    // Per-channel intake and FIFOs
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        assign w_req[c]    = data_i[c*W +: W];
        // Driven only from registered FIFO state (and reset), never from
        // valid_i/ready_i, so a full FIFO refuses even if popped this cycle.
        assign ready_o[c]  = reset & ~w_full[c];
        assign w_accept[c] = valid_i[c] & ready_o[c];
        assign w_nop[c]    = w_accept[c] &
                             (op_t'(w_req[c][W-1 -: OP_WIDTH]) == OP_NOP);
        assign w_push[c]   = w_accept[c] & ~w_nop[c];
        assign w_pop[c]    = w_load & w_any & (w_grant == CW'(c));
        // Search order: last_grant+1, last_grant+2, ... wrapping.
        assign w_cand[c]   = CW'((int'(r_last_grant) + c + 1) % NUM_CHANNELS);

        hash_req_fifo #(
            .WIDTH (W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[c]),
            .i_data  (w_req[c]),
            .i_pop   (w_pop[c]),
            .o_data  (w_head[c]),
            .o_full  (w_full[c]),
            .o_empty (w_empty[c])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin winner: first non-empty FIFO in candidate order
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!w_any && !w_empty[w_cand[i]]) begin
                w_any   = 1'b1;
                w_grant = w_cand[i];
            end
        end
    end

    always_comb begin
        w_nop_count = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_nop_count = w_nop_count + 5'(w_nop[i]);
        end
        w_drop_sum = SW'(r_drop_cnt) + SW'(w_nop_count);
    end

    // ------------------------------------------------------------------
    // Output register and grant pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_chan       <= '0;
            r_last_grant <= CW'(NUM_CHANNELS - 1);
        end else if (w_load) begin
            r_valid <= w_any;
            // Data/channel are only rewritten on a grant, which also keeps
            // them stable under back-pressure.
            if (w_any) begin
                r_data       <= w_head[w_grant];
                r_chan       <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    assign w_out_fire = r_valid & ready_i;
    assign w_out_op   = op_t'(r_data[W-1 -: OP_WIDTH]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_cnt   <= '0;
            r_write_cnt  <= '0;
            r_delete_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_cnt <= (w_drop_sum > CNT_MAX) ? '1 : w_drop_sum[CNT_WIDTH-1:0];
            if (w_out_fire) begin
                case (w_out_op)
                    OP_READ: begin
                        if (r_read_cnt != '1) r_read_cnt <= r_read_cnt + CNT_WIDTH'(1);
                    end
                    OP_WRITE: begin
                        if (r_write_cnt != '1) r_write_cnt <= r_write_cnt + CNT_WIDTH'(1);
                    end
                    OP_DELETE: begin
                        if (r_delete_cnt != '1) r_delete_cnt <= r_delete_cnt + CNT_WIDTH'(1);
                    end
                    default: begin
                        // Nops never reach the output register.
                    end
                endcase
            end
        end
    end

    assign data_o     = r_data;
    assign chan_o     = r_chan;
    assign valid_o    = r_valid;
    assign read_cnt   = r_read_cnt;
    assign write_cnt  = r_write_cnt;
    assign delete_cnt = r_delete_cnt;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_hash_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hash_req_arbiter
// Directed bench for hash_req_arbiter. A second instance with 2-bit
// counters exercises saturation.
// ---------------------------------------------------------------------------
module tb_hash_req_arbiter;
    import hash_pkg::*;

    localparam int NC = 4;
    localparam int KW = 32;
    localparam int DW = 30;
    localparam int W  = 2 + KW + DW;
    localparam int CW = 2;

    logic              clk;
    logic              reset;
    logic [NC*W-1:0]   data_i;
    logic [NC-1:0]     valid_i;
    logic [NC-1:0]     ready_o;
    logic [W-1:0]      data_o;
    logic [CW-1:0]     chan_o;
    logic              valid_o;
    logic              ready_i;
    logic [15:0]       read_cnt, write_cnt, delete_cnt, drop_cnt;

    logic [NC*W-1:0]   d2_data_i;
    logic [NC-1:0]     d2_valid_i;
    logic [NC-1:0]     d2_ready_o;
    logic [W-1:0]      d2_data_o;
    logic [CW-1:0]     d2_chan_o;
    logic              d2_valid_o;
    logic              d2_ready_i;
    logic [1:0]        d2_read_cnt, d2_write_cnt, d2_delete_cnt, d2_drop_cnt;

    int total = 0;
    int bad   = 0;

    hash_req_arbiter dut (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .chan_o(chan_o), .valid_o(valid_o),
        .ready_i(ready_i), .read_cnt(read_cnt), .write_cnt(write_cnt),
        .delete_cnt(delete_cnt), .drop_cnt(drop_cnt)
    );

    hash_req_arbiter #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .data_i(d2_data_i), .valid_i(d2_valid_i),
        .ready_o(d2_ready_o), .data_o(d2_data_o), .chan_o(d2_chan_o),
        .valid_o(d2_valid_o), .ready_i(d2_ready_i), .read_cnt(d2_read_cnt),
        .write_cnt(d2_write_cnt), .delete_cnt(d2_delete_cnt), .drop_cnt(d2_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input op_t op, input logic [KW-1:0] key,
                                        input logic [DW-1:0] dat);
        return {op, key, dat};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_i     = '0;
        valid_i    = '0;
        ready_i    = 1'b0;
        d2_data_i  = '0;
        d2_valid_i = '0;
        d2_ready_i = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        sync();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        total++;
        if ({valid_o, chan_o, data_o} !== '0) begin
            bad++; $display("FAIL reset_out: got v=%0b c=%0d d=%0h want all zero", valid_o, chan_o, data_o);
        end
        total++;
        if ({read_cnt, write_cnt, delete_cnt, drop_cnt} !== 64'h0) begin
            bad++; $display("FAIL reset_cnt: got %0h/%0h/%0h/%0h want 0", read_cnt, write_cnt, delete_cnt, drop_cnt);
        end
        total++;
        if (ready_o !== 4'h0) begin
            bad++; $display("FAIL reset_ready: got %0h want 0", ready_o);
        end
        // Requests presented during reset must be ignored.
        for (int c = 0; c < NC; c++) data_i[c*W +: W] = mk(OP_WRITE, 32'(c), '0);
        valid_i = '1;
        sync();
        valid_i = '0;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (ready_o !== 4'hF) begin
            bad++; $display("FAIL post_reset_ready: got %0h want f", ready_o);
        end
        sync();
        total++;
        if (valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_ignores_valid: got valid_o=%0b want 0", valid_o);
        end
    endtask

    task automatic test_single_write();
        pulse_reset();
        ready_i = 1'b1;
        data_i[0 +: W] = mk(OP_WRITE, 32'd2, 30'd2);
        valid_i = 4'b0001;
        sync();
        valid_i = '0;
        total++;
        if (valid_o !== 1'b0) begin
            bad++; $display("FAIL write_latency1: got valid_o=%0b want 0", valid_o);
        end
        sync();
        total++;
        if ({valid_o, chan_o, data_o} !== {1'b1, 2'd0, mk(OP_WRITE, 32'd2, 30'd2)}) begin
            bad++; $display("FAIL write_out: got v=%0b c=%0d d=%0h want v=1 c=0 d=%0h",
                            valid_o, chan_o, data_o, mk(OP_WRITE, 32'd2, 30'd2));
        end
        sync();
        total++;
        if ({write_cnt, read_cnt, valid_o} !== {16'd1, 16'd0, 1'b0}) begin
            bad++; $display("FAIL write_cnt: got w=%0d r=%0d v=%0b want w=1 r=0 v=0", write_cnt, read_cnt, valid_o);
        end
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] exp_c;
        pulse_reset();
        for (int c = 0; c < NC; c++) data_i[c*W +: W] = mk(OP_READ, 32'(16 + c), '0);
        valid_i = '1;
        ready_i = 1'b1;
        for (int k = 0; k < 13; k++) begin
            sync();
            if (k == 0) begin
                total++;
                if (valid_o !== 1'b0) begin
                    bad++; $display("FAIL rr_prime: got valid_o=%0b want 0", valid_o);
                end
            end else begin
                exp_c = CW'((k - 1) % NC);
                total++;
                if ({valid_o, chan_o, data_o} !== {1'b1, exp_c, mk(OP_READ, 32'(16 + int'(exp_c)), '0)}) begin
                    bad++; $display("FAIL rr_seq%0d: got v=%0b c=%0d want v=1 c=%0d", k, valid_o, chan_o, exp_c);
                end
            end
        end
        valid_i = '0;
        total++;
        if (read_cnt !== 16'd11) begin
            bad++; $display("FAIL rr_read_cnt: got %0d want 11", read_cnt);
        end
    endtask

    task automatic test_backpressure();
        int  n;
        logic acc;
        pulse_reset();
        n = 0;
        data_i[1*W +: W] = mk(OP_WRITE, 32'd100, '0);
        valid_i = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            acc = ready_o[1];
            sync();
            if (acc) begin
                n++;
                data_i[1*W +: W] = mk(OP_WRITE, 32'(100 + n), 30'(n));
            end
            if (i >= 1) begin
                total++;
                if ({valid_o, data_o} !== {1'b1, mk(OP_WRITE, 32'd100, '0)}) begin
                    bad++; $display("FAIL bp_hold%0d: got v=%0b d=%0h want v=1 key 100", i, valid_o, data_o);
                end
            end
        end
        total++;
        if ({n[3:0], ready_o[1]} !== {4'd5, 1'b0}) begin
            bad++; $display("FAIL bp_accepts: got n=%0d ready=%0b want n=5 ready=0", n, ready_o[1]);
        end
        valid_i = '0;
        ready_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            total++;
            if ({valid_o, chan_o, data_o} !== {1'b1, 2'd1, mk(OP_WRITE, 32'(100 + j), 30'(j))}) begin
                bad++; $display("FAIL bp_order%0d: got v=%0b c=%0d d=%0h want key %0d", j, valid_o, chan_o, data_o, 100 + j);
            end
            sync();
        end
        total++;
        if ({valid_o, write_cnt} !== {1'b0, 16'd5}) begin
            bad++; $display("FAIL bp_drain: got v=%0b w=%0d want v=0 w=5", valid_o, write_cnt);
        end
    endtask

    task automatic test_nop();
        pulse_reset();
        ready_i = 1'b1;
        data_i[2*W +: W] = mk(OP_NOP, 32'd7, '0);
        valid_i = 4'b0100;
        sync();
        valid_i = '0;
        total++;
        if (drop_cnt !== 16'd1) begin
            bad++; $display("FAIL nop_drop: got %0d want 1", drop_cnt);
        end
        sync();
        sync();
        total++;
        if (valid_o !== 1'b0) begin
            bad++; $display("FAIL nop_no_out: got valid_o=%0b want 0", valid_o);
        end
        data_i[2*W +: W] = mk(OP_READ, 32'd8, '0);
        valid_i = 4'b0100;
        sync();
        valid_i = '0;
        sync();
        total++;
        if ({valid_o, chan_o, data_o} !== {1'b1, 2'd2, mk(OP_READ, 32'd8, '0)}) begin
            bad++; $display("FAIL nop_read_out: got v=%0b c=%0d d=%0h want v=1 c=2 key 8", valid_o, chan_o, data_o);
        end
        sync();
        total++;
        if ({read_cnt, drop_cnt} !== {16'd1, 16'd1}) begin
            bad++; $display("FAIL nop_read_cnt: got r=%0d drop=%0d want r=1 drop=1", read_cnt, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int  n;
        logic acc;
        // Runs straight after test_nop, so read/drop counters are non-zero.
        n = 0;
        ready_i = 1'b0;
        valid_i = 4'b0010;
        data_i[1*W +: W] = mk(OP_WRITE, 32'd50, '0);
        for (int i = 0; i < 10 && n < 4; i++) begin
            acc = ready_o[1];
            sync();
            if (acc) begin
                n++;
                data_i[1*W +: W] = mk(OP_WRITE, 32'(50 + n), '0);
            end
        end
        valid_i = '0;
        total++;
        if ({n[3:0], valid_o} !== {4'd4, 1'b1}) begin
            bad++; $display("FAIL mid_setup: got n=%0d v=%0b want n=4 v=1", n, valid_o);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({valid_o, chan_o, data_o, ready_o} !== '0) begin
            bad++; $display("FAIL mid_out: got v=%0b c=%0d d=%0h rdy=%0h want all zero", valid_o, chan_o, data_o, ready_o);
        end
        total++;
        if ({read_cnt, write_cnt, delete_cnt, drop_cnt} !== 64'h0) begin
            bad++; $display("FAIL mid_cnt: got %0d/%0d/%0d/%0d want 0", read_cnt, write_cnt, delete_cnt, drop_cnt);
        end
        #1;
        reset = 1'b1;
        ready_i = 1'b1;
        sync();
        total++;
        if (valid_o !== 1'b0) begin
            bad++; $display("FAIL mid_flushed: got valid_o=%0b want 0", valid_o);
        end
        for (int c = 0; c < NC; c++) data_i[c*W +: W] = mk(OP_READ, 32'(200 + c), '0);
        valid_i = '1;
        sync();
        valid_i = '0;
        sync();
        total++;
        if ({valid_o, chan_o, data_o} !== {1'b1, 2'd0, mk(OP_READ, 32'd200, '0)}) begin
            bad++; $display("FAIL mid_first_grant: got v=%0b c=%0d want v=1 c=0", valid_o, chan_o);
        end
        sync();
        total++;
        if ({valid_o, chan_o} !== {1'b1, 2'd1}) begin
            bad++; $display("FAIL mid_second_grant: got v=%0b c=%0d want v=1 c=1", valid_o, chan_o);
        end
        for (int i = 0; i < 4; i++) sync();
    endtask

    task automatic test_saturation();
        int  n;
        logic acc;
        n = 0;
        d2_ready_i = 1'b1;
        d2_valid_i = 4'b0001;
        d2_data_i[0 +: W] = mk(OP_DELETE, 32'd0, '0);
        for (int i = 0; i < 20 && n < 5; i++) begin
            acc = d2_ready_o[0];
            sync();
            if (acc) begin
                n++;
                d2_data_i[0 +: W] = mk(OP_DELETE, 32'(n), '0);
            end
        end
        d2_valid_i = '0;
        for (int i = 0; i < 5; i++) sync();
        total++;
        if (n !== 5) begin
            bad++; $display("FAIL sat_accepts: got %0d want 5", n);
        end
        total++;
        if ({d2_delete_cnt, d2_read_cnt, d2_write_cnt, d2_valid_o} !== {2'd3, 2'd0, 2'd0, 1'b0}) begin
            bad++; $display("FAIL sat_delete_cnt: got del=%0d r=%0d w=%0d v=%0b want del=3 r=0 w=0 v=0",
                            d2_delete_cnt, d2_read_cnt, d2_write_cnt, d2_valid_o);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_backpressure();
        test_nop();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hash_req_arbiter.md
HASH_REQ_ARBITER -- requirements
Module: hash_req_arbiter

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, key field width.
REQ-002 SHALL have parameter DATA_WIDTH, default 30, data field width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, number of requester channels (legal range 2..16).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, entries per channel FIFO (legal: power of two, at least 2).
REQ-005 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-006 SHALL have one clock and an asynchronous active-low reset, listed first: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low).
REQ-007 SHALL have port data_i, input, NUM_CHANNELS*W where W=2+KEY_WIDTH+DATA_WIDTH: per-channel {op[1:0], key, data}, channel c at slice [c*W +: W].
REQ-008 SHALL have port valid_i, input, NUM_CHANNELS: per-channel request valid.
REQ-009 SHALL have port ready_o, output, NUM_CHANNELS: per-channel accept.
REQ-010 SHALL have port data_o, output, W: granted request toward the hash table.
REQ-011 SHALL have port chan_o, output, $clog2(NUM_CHANNELS): source channel of data_o.
REQ-012 SHALL have port valid_o, output, 1, and port ready_i, input, 1: output stream handshake.
REQ-013 SHALL have ports read_cnt, write_cnt, delete_cnt, drop_cnt, output, CNT_WIDTH each: statistics.

Function
REQ-014 SHALL encode op as 2'b01 read, 2'b10 write, 2'b11 delete, 2'b00 nop.
REQ-015 SHALL buffer each channel in its own FIFO of FIFO_DEPTH entries; ready_o[c] SHALL equal "FIFO c not full", with no combinational path from valid_i or ready_i.
REQ-016 SHALL complete an input handshake when valid_i[c] and ready_o[c] are both 1 at a rising edge.
REQ-017 SHALL discard an accepted nop without enqueueing it and increment drop_cnt.
REQ-018 SHALL NOT accept on channel c while FIFO c is full, even if that FIFO is popped in the same cycle.
REQ-019 SHALL hold one output register (data_o, chan_o, valid_o); it is loadable when valid_o==0 or ready_i==1.
REQ-020 SHALL, when the output register is loadable and at least one FIFO is non-empty, pop the round-robin winner's head into the output register at the next edge; otherwise valid_o SHALL clear if ready_i consumed the word.
REQ-021 SHALL apply round-robin priority starting at (last_grant+1) mod NUM_CHANNELS, wrapping, and SHALL update last_grant only on a grant.
REQ-022 SHALL keep data_o and chan_o stable while valid_o==1 and ready_i==0.
REQ-023 SHALL have latency: a request accepted into an empty system at edge k appears on valid_o after edge k+1; sustained throughput SHALL be one request per cycle.
REQ-024 SHALL preserve per-channel order; no ordering is guaranteed between channels.
REQ-025 SHALL increment read_cnt, write_cnt or delete_cnt by op at each output handshake (valid_o and ready_i both 1).
REQ-026 SHALL saturate all counters at all-ones (no wrap).
REQ-027 SHALL, on simultaneous enqueue and pop of the same FIFO, update occupancy by net zero.

Reset
REQ-028 SHALL, while reset==0, asynchronously force: all FIFOs empty; valid_o=0, data_o=0, chan_o=0; last_grant=NUM_CHANNELS-1 so channel 0 wins first; all counters 0.
REQ-029 SHALL force ready_o=0 while reset==0 and SHALL ignore valid_i during reset.
REQ-030 SHALL discard FIFO contents and any held output word on reset asserted mid-operation, with no partial state retained.

Structure
REQ-031 SHALL place op encodings (OP_NOP, OP_READ, OP_WRITE, OP_DELETE) and the op_t 2-bit typedef in shared package hash_pkg.
REQ-032 SHALL instantiate sub-module hash_req_fifo (parametrised width and depth, full/empty flags, same clk/reset) once per channel.

Verification
REQ-033 SHALL verify: after reset, channel 0 writes {10, key 2, data 2}, ready_i=1 -> valid_o=1 two edges later with chan_o=0, write_cnt=1.
REQ-034 SHALL verify: all 4 channels valid every cycle with ready_i=1 -> chan_o sequence 0,1,2,3,0,... and no cycle without valid_o once primed.
REQ-035 SHALL verify: ready_i=0 with channel 1 streaming -> ready_o[1] drops after 4 accepts plus 1 held in the output register; data_o stays constant; on ready_i=1, keys emerge in input order.
REQ-036 SHALL verify: a nop on channel 2 -> no output word, drop_cnt=1; a following read of key 8 -> read_cnt=1.
REQ-037 SHALL verify: reset pulsed low with 3 words queued and valid_o=1 -> valid_o=0 immediately, counters 0, and after release the first grant is channel 0.
REQ-038 SHALL verify: with CNT_WIDTH=2, five deletes output -> delete_cnt=3.
